ysyx_23060042_mcyc_ctrl: RTL and testbench
==========================================

// Module: ysyx_23060042_mcyc_ctrl
// PURPOSE
//  Multi-cycle sequencer for the NPC core. It owns the PC and the instruction register,
//  and steps each instruction through FETCH -> EXEC -> (MEM) -> WB. It gates the IFU and
//  LSU requests and the register-file write enable around the combinational IDU/EXU datapath.
//  It also handles halt (ebreak), and watchdog timeouts on the IFU and LSU handshakes.
// PARAMETERS
//  RESET_PC   32'h8000_0000  PC loaded on reset
//  TIMEOUT    255            max cycles waiting in FETCH or MEM before error
//  CNT_W      8              watchdog counter width; TIMEOUT must be < 2**CNT_W
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous reset, active-high
//  ifu_req      out  1   fetch request; held high in FETCH
//  ifu_addr     out  32  fetch address (= pc)
//  ifu_rvalid   in   1   fetched word valid this cycle
//  ifu_rdata    in   32  fetched instruction word
//  inst         out  32  instruction register, feeds IDU/EXU
//  pc           out  32  current PC, feeds EXU
//  mem_access   in   1   decoded load/store (Mren!=0 or store), sampled in EXEC
//  lsu_req      out  1   LSU request; held high in MEM
//  lsu_done     in   1   LSU access complete this cycle
//  rd_wen       in   1   decoded instruction writes rd
//  rf_wen       out  1   register-file write strobe
//  brch_en      in   1   EXU branch taken
//  jmp_en       in   1   decoded jal/jalr
//  jmp_target   in   32  branch/jump target (pc+imm or rs1+imm, already masked)
//  halt_req     in   1   decoded ebreak
//  halted       out  1   sticky: core halted by ebreak
//  err          out  1   sticky: watchdog expired
//  inst_cnt     out  64  retired-instruction counter
// BEHAVIOUR
//  - States: RST_WAIT, FETCH, EXEC, MEM, WB, HALT, ERR.
//  - Reset (rst=1 at posedge, any state): state=RST_WAIT, pc=RESET_PC, inst=0, inst_cnt=0,
//    watchdog=0, halted=0, err=0. All strobes are 0 while in reset.
//  - RST_WAIT: one cycle, no requests -> FETCH.
//  - FETCH: ifu_req=1, ifu_addr=pc.
//    - On ifu_rvalid: inst<=ifu_rdata, watchdog<=0 -> EXEC.
//    - Otherwise watchdog++. When watchdog==TIMEOUT with no rvalid -> ERR.
//  - EXEC: exactly 1 cycle; the datapath settles on inst/pc. Priority order:
//    - halt_req -> HALT, with no write and no PC update.
//    - else mem_access -> MEM.
//    - else -> WB.
//  - MEM: lsu_req=1. On lsu_done -> WB, watchdog<=0. Otherwise watchdog++.
//    When watchdog==TIMEOUT -> ERR.
//  - WB: 1 cycle. rf_wen=rd_wen.
//    - pc <= (brch_en|jmp_en) ? jmp_target : pc+32'd4 (32-bit wrap; 0xFFFF_FFFC+4 = 0).
//    - inst_cnt++ (64-bit wrap).
//    - -> FETCH.
//  - HALT: halted=1, all requests 0, pc/inst/inst_cnt frozen; only rst exits.
//  - ERR: err=1, all requests 0, state frozen; only rst exits.
//  - Handshake timing:
//    - ifu_rvalid outside FETCH and lsu_done outside MEM are ignored.
//    - Same-cycle rvalid is accepted even on the TIMEOUT-th wait cycle; the response
//      wins over the timeout.
//  - Outputs are registered or decoded from state only. rf_wen is the exception: it is
//    combinational from state==WB & rd_wen. No combinational path from ifu_rvalid or
//    lsu_done to any output.
//  - Latency: non-memory instruction = 3 cycles + IFU wait; memory instruction = 4 + IFU
//    wait + LSU wait.
// TESTING
//  - Reset: hold rst 2 cycles. Expect pc=0x8000_0000, ifu_req=0 in the cycle after
//    release, ifu_req=1 the next cycle.
//  - ALU op: IFU returns addi with rvalid after 0 waits, rd_wen=1. Expect rf_wen for exactly
//    1 cycle 2 cycles after rvalid, pc=0x8000_0004, inst_cnt=1.
//  - Taken branch: brch_en=1, jmp_target=0x8000_0100. Expect next ifu_addr=0x8000_0100 and
//    no rf_wen when rd_wen=0.
//  - Load: mem_access=1, lsu_done after 5 cycles. Expect lsu_req high exactly 6 cycles,
//    rf_wen 1 cycle after lsu_done, pc+4.
//  - Halt: halt_req=1 with mem_access=1 in EXEC. Expect HALT with no lsu_req, halted=1,
//    pc frozen; rst mid-HALT returns pc to 0x8000_0000.
//  - Watchdog: TIMEOUT=4, never assert ifu_rvalid. Expect err=1 after 4 FETCH cycles. Also
//    rvalid on the 4th wait cycle -> EXEC, err=0.

Source files
------------

// File: rtl/ysyx_23060042_mcyc_ctrl_if.sv
// Sequencer <-> core bundle: IFU/LSU handshakes, decode inputs and architectural state outputs.
// master = sequencer side, slave = datapath/memory side.
interface ysyx_23060042_mcyc_ctrl_if;
   logic        ifu_req;
   logic [31:0] ifu_addr;
   logic        ifu_rvalid;
   logic [31:0] ifu_rdata;
   logic [31:0] inst;
   logic [31:0] pc;
   logic        mem_access;
   logic        lsu_req;
   logic        lsu_done;
   logic        rd_wen;
   logic        rf_wen;
   logic        brch_en;
   logic        jmp_en;
   logic [31:0] jmp_target;
   logic        halt_req;
   logic        halted;
   logic        err;
   logic [63:0] inst_cnt;

   modport master (
      output ifu_req, ifu_addr, inst, pc, lsu_req, rf_wen, halted, err, inst_cnt,
      input  ifu_rvalid, ifu_rdata, mem_access, lsu_done, rd_wen, brch_en, jmp_en,
             jmp_target, halt_req
   );

   modport slave (
      input  ifu_req, ifu_addr, inst, pc, lsu_req, rf_wen, halted, err, inst_cnt,
      output ifu_rvalid, ifu_rdata, mem_access, lsu_done, rd_wen, brch_en, jmp_en,
             jmp_target, halt_req
   );
endinterface

// File: rtl/ysyx_23060042_mcyc_ctrl.sv
// Multi-cycle NPC sequencer: FETCH -> EXEC -> (MEM) -> WB, owns PC/IR, halt and handshake watchdog.
// 3 cycles per ALU op + IFU wait, 4 per memory op + IFU/LSU wait; stalls in FETCH/MEM until response.
module ysyx_23060042_mcyc_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter int          TIMEOUT  = 255,
   parameter int          CNT_W    = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   ysyx_23060042_mcyc_ctrl_if.master   bus
);

   typedef enum logic [2:0] {
      RST_WAIT,
      FETCH,
      EXEC,
      MEM,
      WB,
      HALT,
      ERR
   } state_e;

   localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT);

   state_e             state_q, state_d;
   logic [31:0]        pc_q, pc_d;
   logic [31:0]        inst_q, inst_d;
   logic [63:0]        cnt_q, cnt_d;
   logic [CNT_W-1:0]   wd_q, wd_d;
   logic [CNT_W-1:0]   wd_inc;

   assign wd_inc = wd_q + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RST_WAIT;
         pc_q    <= RESET_PC;
         inst_q  <= 32'd0;
         cnt_q   <= 64'd0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         cnt_q   <= cnt_d;
         wd_q    <= wd_d;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      cnt_d   = cnt_q;
      wd_d    = wd_q;
      unique case (state_q)
         RST_WAIT: state_d = FETCH;
         // A response on the last allowed wait cycle still wins over the timeout.
         FETCH: begin
            if (bus.ifu_rvalid) begin
               inst_d  = bus.ifu_rdata;
               wd_d    = '0;
               state_d = EXEC;
            end else begin
               wd_d = wd_inc;
               if (wd_inc == WD_LIMIT) state_d = ERR;
            end
         end
         EXEC: begin
            if (bus.halt_req)        state_d = HALT;
            else if (bus.mem_access) state_d = MEM;
            else                     state_d = WB;
         end
         MEM: begin
            if (bus.lsu_done) begin
               wd_d    = '0;
               state_d = WB;
            end else begin
               wd_d = wd_inc;
               if (wd_inc == WD_LIMIT) state_d = ERR;
            end
         end
         WB: begin
            pc_d    = (bus.brch_en | bus.jmp_en) ? bus.jmp_target : pc_q + 32'd4;
            cnt_d   = cnt_q + 64'd1;
            state_d = FETCH;
         end
         HALT:    state_d = HALT;
         ERR:     state_d = ERR;
         default: state_d = ERR;
      endcase
   end

   assign bus.ifu_req  = (state_q == FETCH);
   assign bus.ifu_addr = pc_q;
   assign bus.inst     = inst_q;
   assign bus.pc       = pc_q;
   assign bus.lsu_req  = (state_q == MEM);
   assign bus.rf_wen   = (state_q == WB) & bus.rd_wen;
   assign bus.halted   = (state_q == HALT);
   assign bus.err      = (state_q == ERR);
   assign bus.inst_cnt = cnt_q;

endmodule

// File: tb/tb_ysyx_23060042_mcyc_ctrl.sv
// Bench for the multi-cycle sequencer: transaction-level model of PC/retire count and per-phase strobes.
module tb_ysyx_23060042_mcyc_ctrl;
   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic clk;
   logic rst;
   logic wrst;
   int   n_vec;
   int   n_err;

   logic [31:0] m_pc;
   logic [63:0] m_cnt;

   ysyx_23060042_mcyc_ctrl_if bus ();
   ysyx_23060042_mcyc_ctrl_if wbus ();

   ysyx_23060042_mcyc_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   ysyx_23060042_mcyc_ctrl #(.TIMEOUT(4)) dut_wd (
      .clk (clk),
      .rst (wrst),
      .bus (wbus.master)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clr_main();
      bus.ifu_rvalid = 1'b0; bus.ifu_rdata = 32'd0; bus.mem_access = 1'b0;
      bus.lsu_done = 1'b0;   bus.rd_wen = 1'b0;     bus.brch_en = 1'b0;
      bus.jmp_en = 1'b0;     bus.jmp_target = 32'd0; bus.halt_req = 1'b0;
   endtask

   task automatic reset_main();
      rst = 1'b1;
      clr_main();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_pc  = RST_PC;
      m_cnt = 64'd0;
      chk("rst_pc", 64'(bus.pc), 64'(RST_PC));
      chk("rst_ifu_req", 64'(bus.ifu_req), 64'd0);
      chk("rst_inst", 64'(bus.inst), 64'd0);
      chk("rst_cnt", bus.inst_cnt, 64'd0);
      chk("rst_flags", 64'({bus.halted, bus.err, bus.lsu_req, bus.rf_wen}), 64'd0);
      @(negedge clk);
      chk("rst_fetch_req", 64'(bus.ifu_req), 64'd1);
   endtask

   // Caller is at a negedge with the DUT in FETCH.
   task automatic run_instr(input int waits, input bit mem, input int lw, input bit rdw,
                            input bit tk, input logic [31:0] tgt, input bit hlt,
                            input logic [31:0] word);
      bit sel;
      sel = 1'($urandom % 2);
      bus.mem_access = mem;
      bus.rd_wen     = rdw;
      bus.brch_en    = tk & sel;
      bus.jmp_en     = tk & ~sel;
      bus.jmp_target = tgt;
      bus.halt_req   = hlt;
      for (int k = 0; k <= waits; k++) begin
         chk("fetch_req", 64'(bus.ifu_req), 64'd1);
         chk("fetch_addr", 64'(bus.ifu_addr), 64'(m_pc));
         chk("fetch_quiet", 64'({bus.lsu_req, bus.rf_wen, bus.halted, bus.err}), 64'd0);
         chk("fetch_cnt", bus.inst_cnt, m_cnt);
         bus.ifu_rvalid = (k == waits);
         bus.ifu_rdata  = (k == waits) ? word : $urandom;
         bus.lsu_done   = 1'($urandom % 2);
         @(negedge clk);
      end
      chk("exec_inst", 64'(bus.inst), 64'(word));
      chk("exec_pc", 64'(bus.pc), 64'(m_pc));
      chk("exec_quiet", 64'({bus.ifu_req, bus.lsu_req, bus.rf_wen}), 64'd0);
      bus.ifu_rvalid = 1'($urandom % 2);
      bus.ifu_rdata  = $urandom;
      bus.lsu_done   = 1'($urandom % 2);
      @(negedge clk);
      if (hlt) begin
         for (int h = 0; h < 3; h++) begin
            chk("halt_flag", 64'(bus.halted), 64'd1);
            chk("halt_quiet", 64'({bus.ifu_req, bus.lsu_req, bus.rf_wen, bus.err}), 64'd0);
            chk("halt_pc", 64'(bus.pc), 64'(m_pc));
            chk("halt_cnt", bus.inst_cnt, m_cnt);
            bus.ifu_rvalid = 1'($urandom % 2);
            bus.lsu_done   = 1'($urandom % 2);
            @(negedge clk);
         end
         return;
      end
      if (mem) begin
         for (int j = 0; j <= lw; j++) begin
            chk("mem_req", 64'(bus.lsu_req), 64'd1);
            chk("mem_quiet", 64'({bus.ifu_req, bus.rf_wen}), 64'd0);
            bus.lsu_done   = (j == lw);
            bus.ifu_rvalid = 1'($urandom % 2);
            @(negedge clk);
         end
      end
      chk("wb_rf_wen", 64'(bus.rf_wen), 64'(rdw));
      chk("wb_quiet", 64'({bus.ifu_req, bus.lsu_req}), 64'd0);
      chk("wb_cnt", bus.inst_cnt, m_cnt);
      bus.ifu_rvalid = 1'($urandom % 2);
      bus.lsu_done   = 1'($urandom % 2);
      @(negedge clk);
      m_pc  = tk ? tgt : m_pc + 32'd4;
      m_cnt = m_cnt + 64'd1;
      bus.ifu_rvalid = 1'b0;
      bus.lsu_done   = 1'b0;
   endtask

   task automatic reset_wd();
      wrst = 1'b1;
      wbus.ifu_rvalid = 1'b0; wbus.ifu_rdata = 32'd0; wbus.mem_access = 1'b0;
      wbus.lsu_done = 1'b0;   wbus.rd_wen = 1'b0;     wbus.brch_en = 1'b0;
      wbus.jmp_en = 1'b0;     wbus.jmp_target = 32'd0; wbus.halt_req = 1'b0;
      repeat (2) @(negedge clk);
      wrst = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      rst   = 1'b1;
      wrst  = 1'b1;
      clr_main();
      m_pc  = RST_PC;
      m_cnt = 64'd0;

      reset_main();
      run_instr(0, 1'b0, 0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0010_0093);
      chk("alu_pc", 64'(bus.pc), 64'h8000_0004);
      chk("alu_cnt", bus.inst_cnt, 64'd1);
      run_instr(2, 1'b0, 0, 1'b0, 1'b1, 32'h8000_0100, 1'b0, 32'h0000_0463);
      chk("br_addr", 64'(bus.ifu_addr), 64'h8000_0100);
      run_instr(1, 1'b1, 5, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0000_2103);
      chk("ld_pc", 64'(bus.pc), 64'h8000_0104);
      run_instr(0, 1'b0, 0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0000_006F);
      run_instr(0, 1'b0, 0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0000_0013);
      chk("wrap_pc", 64'(bus.pc), 64'd0);
      run_instr(3, 1'b0, 0, 1'b1, 1'b1, RST_PC, 1'b0, 32'h0000_0067);

      for (int i = 0; i < 30; i++) begin
         run_instr($urandom_range(6, 0), 1'($urandom % 2), $urandom_range(6, 0),
                   1'($urandom % 2), 1'($urandom % 2), $urandom & 32'hFFFF_FFFC,
                   1'b0, $urandom);
      end

      run_instr(1, 1'b1, 2, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0010_0073);
      reset_main();
      run_instr(0, 1'b1, 0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0000_2183);
      chk("post_halt_pc", 64'(bus.pc), 64'h8000_0004);

      // Watchdog instance: IFU never answers.
      reset_wd();
      for (int k = 1; k <= 4; k++) begin
         chk("wd_fetch_req", 64'(wbus.ifu_req), 64'd1);
         chk("wd_no_err", 64'(wbus.err), 64'd0);
         @(negedge clk);
      end
      for (int k = 0; k < 3; k++) begin
         chk("wd_err", 64'(wbus.err), 64'd1);
         chk("wd_err_quiet", 64'({wbus.ifu_req, wbus.lsu_req, wbus.halted}), 64'd0);
         wbus.ifu_rvalid = 1'b1;
         @(negedge clk);
      end

      // Response on the last allowed wait cycle, then an LSU that never answers.
      reset_wd();
      for (int k = 1; k <= 4; k++) begin
         chk("wd2_fetch_req", 64'(wbus.ifu_req), 64'd1);
         wbus.ifu_rvalid = (k == 4);
         wbus.ifu_rdata  = 32'hCAFE_0003;
         wbus.mem_access = 1'b1;
         @(negedge clk);
      end
      wbus.ifu_rvalid = 1'b0;
      chk("wd2_exec_err", 64'(wbus.err), 64'd0);
      chk("wd2_exec_inst", 64'(wbus.inst), 64'hCAFE_0003);
      @(negedge clk);
      for (int k = 1; k <= 4; k++) begin
         chk("wd2_mem_req", 64'(wbus.lsu_req), 64'd1);
         chk("wd2_mem_noerr", 64'(wbus.err), 64'd0);
         @(negedge clk);
      end
      chk("wd2_mem_err", 64'(wbus.err), 64'd1);
      chk("wd2_mem_quiet", 64'(wbus.lsu_req), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
